// File: rtl/mv_find_topk.sv
// Streaming top-K tracker: keeps the K best-scoring samples of a frame, ranked,
// with their position tags. One sample per cycle, single-cycle sorted insertion.
//
// state  | meaning
// S_IDLE | waiting for iStart; table holds the last frame's result
// S_ACC  | accumulating samples into the ranked table
// S_DONE | one-cycle result strobe, table final
module mv_find_topk #(
    parameter int DATA_W   = 32,
    parameter int POS_W    = 13,
    parameter int K        = 4,
    parameter int FIND_MIN = 0,
    localparam int CNT_W   = $clog2(K + 1)
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iStart,
    input  logic                  iValid,
    input  logic                  iLast,
    input  logic [DATA_W-1:0]     iData_in,
    input  logic [POS_W-1:0]      iPosition,
    output logic [K*DATA_W-1:0]   oMax_val,
    output logic [K*POS_W-1:0]    oPosition,
    output logic [CNT_W-1:0]      oCount,
    output logic                  oValid,
    output logic                  oBusy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_valid;
    logic               r_busy;
    logic [CNT_W-1:0]   r_count;
    logic [DATA_W-1:0]  r_val [K];
    logic [POS_W-1:0]   r_pos [K];

    logic               w_take;
    logic [CNT_W-1:0]   w_base_cnt;
    logic [CNT_W-1:0]   w_new_cnt;
    logic [DATA_W-1:0]  w_base_val  [K];
    logic [POS_W-1:0]   w_base_pos  [K];
    logic [DATA_W-1:0]  w_shift_val [K];
    logic [POS_W-1:0]   w_shift_pos [K];
    logic [DATA_W-1:0]  w_new_val   [K];
    logic [POS_W-1:0]   w_new_pos   [K];
    logic [K-1:0]       w_ins;
    logic [K-1:0]       w_first;

    always_comb begin
        w_next = r_state;
        if (iStart) begin
            w_next = (iValid && iLast) ? S_DONE : S_ACC;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_IDLE;
                S_ACC:   if (iValid && iLast) w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign w_take = iValid && (iStart || (r_state == S_ACC));

    // A start in the same cycle as a sample inserts into an already-cleared table.
    always_comb begin
        w_base_cnt = iStart ? '0 : r_count;
        for (int i = 0; i < K; i++) begin
            w_base_val[i] = iStart ? '0 : r_val[i];
            w_base_pos[i] = iStart ? '0 : r_pos[i];
        end
    end

    // Table is kept sorted, so w_ins is a thermometer: 0s above the slot, 1s from it down.
    always_comb begin
        w_ins = '0;
        for (int i = 0; i < K; i++) begin
            if (i >= int'(w_base_cnt)) begin
                w_ins[i] = 1'b1;
            end else if (FIND_MIN != 0) begin
                w_ins[i] = (iData_in < w_base_val[i]);
            end else begin
                w_ins[i] = (iData_in > w_base_val[i]);
            end
        end
    end

    always_comb begin
        w_first        = '0;
        w_shift_val    = '{default: '0};
        w_shift_pos    = '{default: '0};
        w_first[0]     = w_ins[0];
        w_shift_val[0] = iData_in;
        w_shift_pos[0] = iPosition;
        for (int i = 1; i < K; i++) begin
            w_first[i]     = w_ins[i] && !w_ins[i-1];
            w_shift_val[i] = w_base_val[i-1];
            w_shift_pos[i] = w_base_pos[i-1];
        end
    end

    always_comb begin
        w_new_val = '{default: '0};
        w_new_pos = '{default: '0};
        for (int i = 0; i < K; i++) begin
            if (!w_ins[i]) begin
                w_new_val[i] = w_base_val[i];
                w_new_pos[i] = w_base_pos[i];
            end else if (w_first[i]) begin
                w_new_val[i] = iData_in;
                w_new_pos[i] = iPosition;
            end else begin
                w_new_val[i] = w_shift_val[i];
                w_new_pos[i] = w_shift_pos[i];
            end
        end
    end

    always_comb begin
        w_new_cnt = w_base_cnt;
        if ((|w_ins) && (w_base_cnt != CNT_W'(K))) begin
            w_new_cnt = w_base_cnt + 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_val   <= '{default: '0};
            r_pos   <= '{default: '0};
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == S_DONE);
            r_busy  <= (w_next == S_ACC);
            if (w_take) begin
                r_count <= w_new_cnt;
                r_val   <= w_new_val;
                r_pos   <= w_new_pos;
            end else if (iStart) begin
                r_count <= '0;
                r_val   <= '{default: '0};
                r_pos   <= '{default: '0};
            end
        end
    end

    always_comb begin
        oMax_val  = '0;
        oPosition = '0;
        for (int i = 0; i < K; i++) begin
            oMax_val[i*DATA_W +: DATA_W] = r_val[i];
            oPosition[i*POS_W +: POS_W]  = r_pos[i];
        end
    end

    assign oCount = r_count;
    assign oValid = r_valid;
    assign oBusy  = r_busy;

endmodule

// File: tb/tb_mv_find_topk.sv
// Bench for mv_find_topk: a max-ranking and a min-ranking instance share stimulus and
// are compared every cycle against a stable-sort top-K reference model.
module tb_mv_find_topk;

    localparam int DW = 32;
    localparam int PW = 13;
    localparam int KK = 4;
    localparam int CW = 3;

    logic              clk_sys;
    logic              iReset;
    logic              iStart;
    logic              iValid;
    logic              iLast;
    logic [DW-1:0]     iData_in;
    logic [PW-1:0]     iPosition;

    logic [KK*DW-1:0]  max_val0, max_val1;
    logic [KK*PW-1:0]  pos0, pos1;
    logic [CW-1:0]     cnt0, cnt1;
    logic              vld0, vld1, busy0, busy1;

    mv_find_topk #(.DATA_W(DW), .POS_W(PW), .K(KK), .FIND_MIN(0)) dut_max (
        .iClk(clk_sys), .iReset(iReset), .iStart(iStart), .iValid(iValid), .iLast(iLast),
        .iData_in(iData_in), .iPosition(iPosition),
        .oMax_val(max_val0), .oPosition(pos0), .oCount(cnt0), .oValid(vld0), .oBusy(busy0)
    );

    mv_find_topk #(.DATA_W(DW), .POS_W(PW), .K(KK), .FIND_MIN(1)) dut_min (
        .iClk(clk_sys), .iReset(iReset), .iStart(iStart), .iValid(iValid), .iLast(iLast),
        .iData_in(iData_in), .iPosition(iPosition),
        .oMax_val(max_val1), .oPosition(pos1), .oCount(cnt1), .oValid(vld1), .oBusy(busy1)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [DW-1:0] sc;
        logic [PW-1:0] ps;
    } smp_t;

    smp_t q_smp[$];
    bit   m_in_frame;
    bit   m_valid;
    int   n_tests;
    int   n_fail;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Best K of all frame samples, best first; among equal scores the earlier arrival wins.
    task automatic topk(input bit fmin, output logic [127:0] ev, output logic [127:0] ep,
                        output int n);
        smp_t rem[$];
        int   bi;
        rem = q_smp;
        ev  = '0;
        ep  = '0;
        n   = 0;
        while (n < KK && rem.size() > 0) begin
            bi = 0;
            for (int j = 1; j < rem.size(); j++) begin
                if (fmin ? (rem[j].sc < rem[bi].sc) : (rem[j].sc > rem[bi].sc)) bi = j;
            end
            ev[n*DW +: DW] = rem[bi].sc;
            ep[n*PW +: PW] = rem[bi].ps;
            rem.delete(bi);
            n++;
        end
    endtask

    task automatic model_update(input bit s, input bit v, input bit l,
                                input logic [DW-1:0] d, input logic [PW-1:0] p);
        smp_t e;
        e.sc    = d;
        e.ps    = p;
        m_valid = 1'b0;
        if (s) begin
            q_smp.delete();
            m_in_frame = 1'b1;
        end
        if (v && m_in_frame) begin
            q_smp.push_back(e);
            if (l) begin
                m_valid    = 1'b1;
                m_in_frame = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic [127:0] ev, ep;
        int           n;
        topk(1'b0, ev, ep, n);
        chk("max_val",   128'(max_val0), ev);
        chk("max_pos",   128'(pos0), ep);
        chk("max_count", 128'(cnt0), 128'(n));
        topk(1'b1, ev, ep, n);
        chk("min_val",   128'(max_val1), ev);
        chk("min_pos",   128'(pos1), ep);
        chk("min_count", 128'(cnt1), 128'(n));
        chk("valid",     128'({vld1, vld0}), 128'({m_valid, m_valid}));
        chk("busy",      128'({busy1, busy0}), 128'({m_in_frame, m_in_frame}));
    endtask

    task automatic step(input bit s, input bit v, input bit l,
                        input logic [DW-1:0] d, input logic [PW-1:0] p);
        @(negedge clk_sys);
        iStart    = s;
        iValid    = v;
        iLast     = l;
        iData_in  = d;
        iPosition = p;
        @(posedge clk_sys);
        model_update(s, v, l, d, p);
        #1;
        check_all();
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Reset lands between edges so the clear must be asynchronous.
    task automatic async_reset();
        @(negedge clk_sys);
        iStart = 1'b0;
        iValid = 1'b0;
        iLast  = 1'b0;
        #2;
        iReset = 1'b1;
        q_smp.delete();
        m_in_frame = 1'b0;
        m_valid    = 1'b0;
        #1;
        check_all();
        @(negedge clk_sys);
        iReset = 1'b0;
    endtask

    task automatic frame_5_9_3_7_1();
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 32'd5, 13'd0);
        step(1'b0, 1'b1, 1'b0, 32'd9, 13'd1);
        step(1'b0, 1'b1, 1'b0, 32'd3, 13'd2);
        step(1'b0, 1'b1, 1'b0, 32'd7, 13'd3);
        step(1'b0, 1'b1, 1'b1, 32'd1, 13'd4);
        chk("d036_valid",   128'(vld0), 128'd1);
        chk("d036_vals",    128'(max_val0), {32'd3, 32'd5, 32'd7, 32'd9});
        chk("d036_pos",     128'(pos0), 128'({13'd2, 13'd0, 13'd3, 13'd1}));
        chk("d036_count",   128'(cnt0), 128'd4);
        chk("d041_vals",    128'(max_val1), {32'd7, 32'd5, 32'd3, 32'd1});
        chk("d041_pos",     128'(pos1), 128'({13'd3, 13'd0, 13'd2, 13'd4}));
        idle_step();
        chk("d036_pulse",   128'(vld0), 128'd0);
    endtask

    initial begin
        bit in_f;
        int len;
        logic [DW-1:0] d;
        n_tests    = 0;
        n_fail     = 0;
        m_in_frame = 1'b0;
        m_valid    = 1'b0;
        iReset     = 1'b1;
        iStart     = 1'b0;
        iValid     = 1'b0;
        iLast      = 1'b0;
        iData_in   = '0;
        iPosition  = '0;
        #1;
        check_all();
        @(negedge clk_sys);
        iReset = 1'b0;

        frame_5_9_3_7_1();

        // ties keep arrival order
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 32'd8, 13'd10);
        step(1'b0, 1'b1, 1'b0, 32'd8, 13'd11);
        step(1'b0, 1'b1, 1'b1, 32'd8, 13'd12);
        chk("d037_vals",  128'(max_val0), {32'd0, 32'd8, 32'd8, 32'd8});
        chk("d037_pos",   128'(pos0), 128'({13'd0, 13'd12, 13'd11, 13'd10}));
        chk("d037_count", 128'(cnt0), 128'd3);
        idle_step();

        // start, sample and last together
        step(1'b1, 1'b1, 1'b1, 32'd4, 13'd2);
        chk("d038_valid", 128'(vld0), 128'd1);
        chk("d038_entry", 128'({pos0[PW-1:0], max_val0[DW-1:0]}), 128'({13'd2, 32'd4}));
        chk("d038_count", 128'(cnt0), 128'd1);
        idle_step();
        step(1'b0, 1'b1, 1'b1, 32'd99, 13'd5);
        chk("idle_hold",  128'(max_val0[DW-1:0]), 128'd4);

        // restart mid-frame
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 32'd6, 13'd0);
        step(1'b0, 1'b1, 1'b0, 32'd2, 13'd1);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        chk("d039_busy",  128'(busy0), 128'd1);
        chk("d039_valid", 128'(vld0), 128'd0);
        step(1'b0, 1'b0, 1'b1, 32'd50, 13'd7);
        step(1'b0, 1'b1, 1'b1, 32'd1, 13'd2);
        chk("d039_vals",  128'(max_val0), {32'd0, 32'd0, 32'd0, 32'd1});
        chk("d039_count", 128'(cnt0), 128'd1);
        idle_step();

        // reset mid-frame, then a normal frame right after release
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 32'd11, 13'd1);
        step(1'b0, 1'b1, 1'b0, 32'd12, 13'd2);
        step(1'b0, 1'b1, 1'b0, 32'd13, 13'd3);
        async_reset();
        chk("d040_zero", 128'({cnt0, busy0, vld0, max_val0}), 128'd0);
        frame_5_9_3_7_1();

        // randomized frames
        in_f = 1'b0;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 3) == 0) idle_step();
            if ($urandom_range(0, 4) == 0) step(1'b0, 1'b1, 1'b0, $urandom, 13'($urandom));
            len = $urandom_range(1, 12);
            d   = ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 15)) : $urandom;
            step(1'b1, $urandom_range(0, 1) != 0, len == 1, d, 13'($urandom));
            in_f = (len != 1);
            while (in_f) begin
                d = ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 15)) : $urandom;
                case ($urandom_range(0, 19))
                    0: begin
                        step(1'b1, 1'b1, 1'b0, d, 13'($urandom));
                    end
                    1: begin
                        step(1'b0, 1'b0, 1'b1, d, 13'($urandom));
                    end
                    2: begin
                        if (f % 7 == 3) begin
                            async_reset();
                            in_f = 1'b0;
                        end else begin
                            idle_step();
                        end
                    end
                    default: begin
                        len--;
                        step(1'b0, 1'b1, len <= 1, d, 13'($urandom));
                        if (len <= 1) in_f = 1'b0;
                    end
                endcase
            end
            idle_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
